// File: rtl/fft_pkg.sv
// Shared FFT definitions: default widths, reorder FSM states and a bit-reversal
// helper that the FFT address generators can also use.
package fft_pkg;

  localparam int W_DEF     = 16;
  localparam int LOG2N_DEF = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Reverses the low `bits` bits of v; bits above that come back as zero.
  function automatic logic [15:0] bitrev(input logic [15:0] v, input int bits);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < bits) r[i] = v[bits-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// Stream bundle for fft_out_reorder: dual-lane capture side and single-lane
// valid/ready replay side.
interface fft_out_reorder_if #(
  parameter int W     = 16,
  parameter int LOG2N = 6
);
  logic             in_valid;
  logic [W-1:0]     in_re0;
  logic [W-1:0]     in_im0;
  logic [W-1:0]     in_re1;
  logic [W-1:0]     in_im1;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_re;
  logic [W-1:0]     out_im;
  logic [LOG2N-1:0] out_idx;
  logic             out_last;

  modport master (
    output in_valid, in_re0, in_im0, in_re1, in_im1, out_ready,
    input  out_valid, out_re, out_im, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_re0, in_im0, in_re1, in_im1, out_ready,
    output out_valid, out_re, out_im, out_idx, out_last
  );
endinterface

// File: rtl/fft_reorder_bank.sv
// Half-frame sample store: synchronous write, asynchronous read, no reset
// (contents are only ever exposed after a full frame has been written).
module fft_reorder_bank #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_out_reorder.sv
// Captures a dual-lane FFT frame, undoes bit-reversed bin order and replays
// it one bin per handshake in natural order.
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int LOG2N  = LOG2N_DEF,
  parameter bit BITREV = 1'b1
) (
  input  logic              clk,
  input  logic              nrst,
  fft_out_reorder_if.slave  io,
  output logic              busy,
  output logic              overrun
);

  localparam int AW = LOG2N - 1;
  localparam int DW = 2 * W;

  state_t           state_q, state_d;
  logic [AW-1:0]    wr_cnt_q, wr_cnt_d;
  logic [LOG2N-1:0] rd_idx_q, rd_idx_d;
  logic             overrun_q;
  logic             wr_en;
  logic [AW-1:0]    waddr;
  logic [DW-1:0]    rdata_l, rdata_h, rdata;

  // Input pairs arriving during DRAIN are dropped so the frame being read stays intact.
  assign wr_en = io.in_valid && (state_q != DRAIN);
  assign waddr = BITREV ? AW'(bitrev(16'(wr_cnt_q), AW)) : wr_cnt_q;

  fft_reorder_bank #(.DW(DW), .AW(AW)) u_bank_l (
    .clk   (clk),
    .we    (wr_en),
    .waddr (waddr),
    .wdata ({io.in_re0, io.in_im0}),
    .raddr (rd_idx_q[AW-1:0]),
    .rdata (rdata_l)
  );

  fft_reorder_bank #(.DW(DW), .AW(AW)) u_bank_h (
    .clk   (clk),
    .we    (wr_en),
    .waddr (waddr),
    .wdata ({io.in_re1, io.in_im1}),
    .raddr (rd_idx_q[AW-1:0]),
    .rdata (rdata_h)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      wr_cnt_q  <= '0;
      rd_idx_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_idx_q  <= rd_idx_d;
      overrun_q <= io.in_valid && (state_q == DRAIN);
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_idx_d = rd_idx_q;
    unique case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          wr_cnt_d = AW'(1);
          state_d  = FILL;
        end
      end
      FILL: begin
        if (io.in_valid) begin
          if (&wr_cnt_q) begin
            wr_cnt_d = '0;
            rd_idx_d = '0;
            state_d  = DRAIN;
          end else begin
            wr_cnt_d = wr_cnt_q + AW'(1);
          end
        end
      end
      DRAIN: begin
        if (io.out_ready) begin
          rd_idx_d = rd_idx_q + LOG2N'(1);
          if (&rd_idx_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdata        = rd_idx_q[LOG2N-1] ? rdata_h : rdata_l;
  assign io.out_valid = (state_q == DRAIN);
  assign io.out_idx   = rd_idx_q;
  assign io.out_last  = (state_q == DRAIN) && (&rd_idx_q);
  assign io.out_re    = io.out_valid ? rdata[DW-1:W] : '0;
  assign io.out_im    = io.out_valid ? rdata[W-1:0] : '0;
  assign busy         = (state_q != IDLE);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Scoreboard bench for fft_out_reorder: random frames through BITREV=1 and
// BITREV=0 instances, checked in natural bin order by an independent monitor.
module tb_fft_out_reorder;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  fft_out_reorder_if #(.W(16), .LOG2N(6)) io1 ();
  fft_out_reorder_if #(.W(16), .LOG2N(6)) io0 ();
  logic busy1, ov1, busy0, ov0;
  logic rdy = 1'b1;
  assign io1.out_ready = rdy;
  assign io0.out_ready = rdy;

  fft_out_reorder #(.W(16), .LOG2N(6), .BITREV(1'b1)) u_dut1 (
    .clk(clk), .nrst(nrst), .io(io1), .busy(busy1), .overrun(ov1));
  fft_out_reorder #(.W(16), .LOG2N(6), .BITREV(1'b0)) u_dut0 (
    .clk(clk), .nrst(nrst), .io(io0), .busy(busy0), .overrun(ov0));

  typedef struct {
    int          idx;
    logic [15:0] re;
    logic [15:0] im;
  } exp_t;

  exp_t        q1[$];
  exp_t        q0[$];
  int          hs1 = 0;
  int          hs0 = 0;
  int          checks = 0;
  int          errors = 0;
  bit          rnd_ready = 1'b0;
  logic [15:0] fre[64];
  logic [15:0] fim[64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int rev5(input int k);
    int r = 0;
    for (int i = 0; i < 5; i++) r = (r << 1) | ((k >> i) & 1);
    return r;
  endfunction

  function automatic logic vld(input int sel);
    return sel != 0 ? io1.out_valid : io0.out_valid;
  endfunction

  // Monitor: compares every presented bin with the head of its queue; pops on handshake.
  always @(negedge clk) begin
    if (nrst) begin
      if (io1.out_valid) begin
        if (q1.size() == 0) chk("extra_bin1", 32'(io1.out_idx), 32'hFFFF_FFFF);
        else begin
          chk("idx1", 32'(io1.out_idx), 32'(q1[0].idx));
          chk("re1", 32'(io1.out_re), 32'(q1[0].re));
          chk("im1", 32'(io1.out_im), 32'(q1[0].im));
          chk("last1", 32'(io1.out_last), 32'(q1[0].idx == 63));
          if (io1.out_ready) begin
            void'(q1.pop_front());
            hs1++;
          end
        end
      end else chk("idle_zero1", {io1.out_re, io1.out_im[14:0], io1.out_last}, 32'd0);
      if (io0.out_valid) begin
        if (q0.size() == 0) chk("extra_bin0", 32'(io0.out_idx), 32'hFFFF_FFFF);
        else begin
          chk("idx0", 32'(io0.out_idx), 32'(q0[0].idx));
          chk("re0", 32'(io0.out_re), 32'(q0[0].re));
          chk("im0", 32'(io0.out_im), 32'(q0[0].im));
          chk("last0", 32'(io0.out_last), 32'(q0[0].idx == 63));
          if (io0.out_ready) begin
            void'(q0.pop_front());
            hs0++;
          end
        end
      end else chk("idle_zero0", {io0.out_re, io0.out_im[14:0], io0.out_last}, 32'd0);
    end
  end

  always @(posedge clk) begin
    #1;
    rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic drive(input int sel, input bit v, input logic [15:0] a, b, c, d);
    if (sel != 0) begin
      io1.in_valid = v; io1.in_re0 = a; io1.in_im0 = b; io1.in_re1 = c; io1.in_im1 = d;
    end else begin
      io0.in_valid = v; io0.in_re0 = a; io0.in_im0 = b; io0.in_re1 = c; io0.in_im1 = d;
    end
  endtask

  task automatic rand_frame();
    for (int b = 0; b < 64; b++) begin
      fre[b] = 16'($urandom);
      fim[b] = 16'($urandom);
    end
  endtask

  // Bins are pushed in natural order; pair k carries bins (rev5(k) or k) and +32.
  task automatic send_frame(input int sel, input int gap_a, input int gap_b, input int exp_edges);
    int n = 0;
    bit early = 1'b0;
    for (int b = 0; b < 64; b++) begin
      exp_t e;
      e.idx = b; e.re = fre[b]; e.im = fim[b];
      if (sel != 0) q1.push_back(e); else q0.push_back(e);
    end
    for (int k = 0; k < 32; k++) begin
      int bb = (sel != 0) ? rev5(k) : k;
      drive(sel, 1'b1, fre[bb], fim[bb], fre[bb+32], fim[bb+32]);
      @(posedge clk); #1;
      n++;
      if (k < 31 && vld(sel)) early = 1'b1;
      if (k == gap_a || k == gap_b) begin
        drive(sel, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
        repeat (3) begin
          @(posedge clk); #1;
          n++;
          if (vld(sel)) early = 1'b1;
        end
      end
    end
    drive(sel, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
    chk("first_valid", 32'(vld(sel)), 32'd1);
    chk("fill_edges", 32'(n), 32'(exp_edges));
    chk("early_valid", 32'(early), 32'd0);
  endtask

  task automatic wait_done(input int sel, input int hs_before);
    bit done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(posedge clk); #1;
      if (!((sel != 0) ? busy1 : busy0)) done = 1'b1;
    end
    chk("drain_done", 32'(done), 32'd1);
    chk("handshakes", 32'((sel != 0 ? hs1 : hs0) - hs_before), 32'd64);
    chk("queue_empty", 32'((sel != 0) ? q1.size() : q0.size()), 32'd0);
  endtask

  task automatic wait_idx1(input int target);
    bit hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      if (io1.out_valid && io1.out_idx == 6'(target)) hit = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("reach_idx", 32'(hit), 32'd1);
  endtask

  initial begin
    int hb;
    nrst = 1'b0;
    drive(1, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
    drive(0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(io1.out_valid), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_ovr", 32'(ov1), 32'd0);
    chk("rst_idx", 32'(io1.out_idx), 32'd0);
    chk("rst_data", 32'({io1.out_re, io1.out_im}), 32'd0);
    chk("rst_valid0", 32'({io0.out_valid, busy0, io0.out_last}), 32'd0);
    @(negedge clk) nrst = 1'b1;
    @(posedge clk); #1;

    // Ramp frame through the bit-reversing instance.
    for (int b = 0; b < 64; b++) begin
      fre[b] = 16'(b);
      fim[b] = 16'(-b);
    end
    hb = hs1; send_frame(1, -1, -1, 32); wait_done(1, hb);

    // Natural-order pass-through.
    rand_frame();
    hb = hs0; send_frame(0, -1, -1, 32); wait_done(0, hb);

    // Random backpressure during drain.
    rand_frame();
    rnd_ready = 1'b1;
    hb = hs1; send_frame(1, -1, -1, 32); wait_done(1, hb);
    rnd_ready = 1'b0;
    @(posedge clk); #1;

    // Input gaps after pairs 5 and 20 stretch the fill by six cycles.
    rand_frame();
    hb = hs1; send_frame(1, 5, 20, 38); wait_done(1, hb);

    // Overrun at rd_idx 10: pair dropped, pulse next cycle, frame unchanged.
    rand_frame();
    hb = hs1; send_frame(1, -1, -1, 32);
    wait_idx1(10);
    chk("ovr_before", 32'(ov1), 32'd0);
    drive(1, 1'b1, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000);
    @(posedge clk); #1;
    drive(1, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
    chk("ovr_pulse", 32'(ov1), 32'd1);
    @(posedge clk); #1;
    chk("ovr_clear", 32'(ov1), 32'd0);
    wait_done(1, hb);

    // Asynchronous reset mid-drain, then a clean frame.
    rand_frame();
    send_frame(1, -1, -1, 32);
    wait_idx1(40);
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_valid", 32'(io1.out_valid), 32'd0);
    chk("arst_busy", 32'(busy1), 32'd0);
    chk("arst_idx", 32'(io1.out_idx), 32'd0);
    chk("arst_data", 32'({io1.out_re, io1.out_im}), 32'd0);
    q1.delete();
    @(posedge clk); #2;
    nrst = 1'b1;
    @(posedge clk); #1;
    rand_frame();
    hb = hs1; send_frame(1, -1, -1, 32); wait_done(1, hb);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
